rd_ptr_ctrl: RTL and testbench
==============================

# rd_ptr_ctrl

Parametrised read-side pointer controller for the asynchronous FIFO, running entirely in the rclk domain. It synchronises the Gray-coded write pointer internally with a configurable-depth flop chain and advances the binary/Gray read pointer on accepted reads. It produces registered empty, almost-empty and fill-count outputs, plus an optional sticky underflow flag. It sits between the dual-port RAM read port and the write-domain full logic, which consumes rptr_gray.

## Interface
- ADDR_WIDTH, 3: RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: write-pointer synchroniser depth; legal values 2..4, elaboration error otherwise.
- rclk  in  1  read clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- r_en  in  1  read request.
- wptr_gray_async  in  ADDR_WIDTH+1  Gray write pointer from wclk domain, unsynchronised.
- ae_level  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static.
- err_clr  in  1  clears underflow.
- raddr  out  ADDR_WIDTH  RAM read address.
- rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer to wclk domain.
- empty  out  1  FIFO empty (pessimistic).
- almost_empty  out  1  rd_count <= ae_level.
- rd_count  out  ADDR_WIDTH+1  entries available, 0..DEPTH.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Synchroniser: SYNC_STAGES flops, all reset to 0; wptr_sync = last stage.
- rd_fire = r_en & !empty. b_next = b_rptr + rd_fire, modulo 2**(ADDR_WIDTH+1). g_next = b_next ^ (b_next >> 1).
- Registers on each rclk edge: b_rptr <= b_next; rptr_gray <= g_next.
- raddr = b_rptr[ADDR_WIDTH-1:0]. Direct register bits, no logic.
- wbin_sync = Gray-to-binary of wptr_sync, using an XOR prefix from the MSB.
- count_next = wbin_sync - b_next, modulo 2**(ADDR_WIDTH+1). Result is always 0..DEPTH.
- Flag and count registers:
  - empty <= (g_next == wptr_sync).
  - rd_count <= count_next.
  - almost_empty <= (count_next <= ae_level).
- Reads while empty are ignored: pointers hold, no RAM side effect.
- Underflow:
  - r_en & empty sets underflow on the next edge.
  - err_clr clears it.
  - Set wins over clear in the same cycle.
- Reset values: b_rptr=0, rptr_gray=0, raddr=0, empty=1, almost_empty=1, rd_count=0, underflow=0, sync chain=0.
- Reset mid-operation clears all of the above immediately (asynchronous). Deassertion takes effect at the next rclk edge.

## Timing
- Accepted read at edge N: raddr, rptr_gray, empty, rd_count and almost_empty all reflect the post-read state after edge N.
- Write pointer change (stable from the write domain): visible in empty, rd_count and almost_empty after SYNC_STAGES+1 rclk edges.
- empty/rd_count are pessimistic: they may lag writes, but never lag reads.
- Pointer wrap at 2**(ADDR_WIDTH+1) is seamless. The MSB difference distinguishes full (count=DEPTH) from empty.
- Simultaneous read and write-pointer update: the count uses both the new b_next and the current wptr_sync. No lost update.

## Configuration
- RD_PTR_UNDERFLOW_EN defined: underflow detection and the sticky register are built as described.
- Not defined: underflow is tied to 0 and err_clr is ignored. All other behaviour is identical, and reads while empty are still blocked.

## Structure
- Shared package async_fifo_pkg:
  - constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4;
  - Gray/binary conversion functions (bin2gray, gray2bin), generic over width via a max-width argument plus masking.
- One sub-module, ptr_sync: a parametrised width × SYNC_STAGES flop chain with asynchronous active-low reset. It is reused by the write-side controller.

## Test plan
ADDR_WIDTH=3, SYNC_STAGES=2, ae_level=2 unless stated.
- Reset mid-stream:
  - Stimulus: with rd_count=5, pulse rrst_n low.
  - Required: empty=1, almost_empty=1, rd_count=0, rptr_gray=0, raddr=0, underflow=0, all before the next rclk edge.
- Sync latency:
  - Stimulus: wptr_gray_async 0 → 4'b0001.
  - Required: empty falls, rd_count=1, almost_empty=1, exactly on the 3rd rclk edge after the change.
- Full drain:
  - Stimulus: wptr=bin 8 (gray 4'b1100), then 8 back-to-back reads.
  - Required:
    - raddr steps 0..7;
    - rptr_gray steps 0,1,3,2,6,7,5,4,12;
    - rd_count 8→0;
    - almost_empty rises when rd_count=2;
    - empty rises at the 8th read edge.
- Wrap-around:
  - Stimulus: b_rptr=15, wptr=bin 1 (gray 4'b0001), then two reads.
  - Required: rd_count 2→1→0, rptr_gray ends 4'b0001, empty=1.
- Underflow (macro on):
  - Stimulus: r_en=1 while empty for 3 cycles.
  - Required: pointers unchanged and underflow=1.
  - err_clr alone → underflow=0. err_clr together with r_en while empty → stays 1.
  - Macro off: underflow remains 0 throughout.
- Concurrent events:
  - Stimulus: read accepted on the same edge the synchronised wptr advances by 1, starting from rd_count=3.
  - Required: rd_count stays 3, almost_empty=0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
//
// Purpose:
//   Definitions shared by the read-side and write-side pointer controllers
//   of the asynchronous FIFO:
//     - legal range for the pointer synchroniser depth;
//     - Gray <-> binary conversion helpers.
//
// The conversion helpers work on a fixed maximum width (PTR_MAX_W). The
// caller passes the real pointer width, and any bits above it are masked
// off. This lets one function serve every pointer width in the design.
// Callers zero-extend their pointer into the function and cast the result
// back down to their own width.
// ---------------------------------------------------------------------------
package async_fifo_pkg;

    // Legal range for the number of synchroniser flops
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Widest pointer the conversion helpers handle
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // Returns a mask with the low 'width' bits set.
    // Widths outside 1..PTR_MAX_W are clamped to that range.
    function automatic ptr_max_t width_mask(input int width);
        int w;
        w = (width > PTR_MAX_W) ? PTR_MAX_W : ((width < 1) ? 1 : width);
        return {PTR_MAX_W{1'b1}} >> (PTR_MAX_W - w);
    endfunction

    // Binary to Gray: adjacent codes differ in exactly one bit
    function automatic ptr_max_t bin2gray(input ptr_max_t bin, input int width);
        ptr_max_t b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above it, built as a running prefix from the MSB downwards. Masked-off
    // upper bits are zero, so they do not disturb the prefix.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray, input int width);
        ptr_max_t g;
        ptr_max_t b;
        g = gray & width_mask(width);
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

endpackage : async_fifo_pkg

// File: rtl/ptr_sync.sv
// ---------------------------------------------------------------------------
// ptr_sync
//
// Purpose:
//   Multi-flop synchroniser for a Gray-coded pointer that crosses a clock
//   domain. It is used by both the read-side and the write-side pointer
//   controllers.
//
//   Only one bit of a Gray pointer changes per increment, so a capture
//   taken mid-transition resolves to either the old or the new value.
//   It never resolves to an unrelated code.
//
// Parameters:
//   WIDTH   pointer width in bits
//   STAGES  number of flops in the chain (SYNC_STAGES_MIN..SYNC_STAGES_MAX)
//
// Ports:
//   clk_i    in   1      destination-domain clock
//   rst_ni   in   1      asynchronous active-low reset; clears every stage
//   d_i      in   WIDTH  pointer from the source domain (unsynchronised)
//   q_o      out  WIDTH  synchronised pointer (last stage)
// ---------------------------------------------------------------------------
module ptr_sync
    import async_fifo_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync: STAGES=%0d outside legal range %0d..%0d",
               STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : ptr_sync

// File: rtl/rd_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// rd_ptr_ctrl
//
// Purpose:
//   Read-side pointer controller of the asynchronous FIFO. Everything here
//   runs in the rclk domain:
//     - synchronises the Gray write pointer through a SYNC_STAGES flop chain;
//     - advances the binary and Gray read pointers on accepted reads;
//     - produces registered empty, almost-empty and fill-count outputs;
//     - optionally keeps a sticky underflow flag.
//
//   The flags are computed from the post-read pointer (b_next/g_next).
//   They therefore never lag a read, but can lag writes by the
//   synchroniser latency, which errs on the safe side.
//
// Configuration macro:
//   RD_PTR_UNDERFLOW_EN  when defined, builds the sticky underflow register
//                        (set by r_en while empty, cleared by err_clr, set
//                        wins). When undefined, underflow is tied to 0 and
//                        err_clr is ignored. Reads while empty are blocked
//                        in both builds.
//
// Parameters:
//   ADDR_WIDTH   RAM address width; depth = 2**ADDR_WIDTH
//   SYNC_STAGES  write-pointer synchroniser depth (2..4)
//
// Ports:
//   rclk             in   1             read clock
//   rrst_n           in   1             asynchronous active-low reset
//   r_en             in   1             read request
//   wptr_gray_async  in   ADDR_WIDTH+1  Gray write pointer, wclk domain
//   ae_level         in   ADDR_WIDTH+1  almost-empty threshold (quasi-static)
//   err_clr          in   1             clears the underflow flag
//   raddr            out  ADDR_WIDTH    RAM read address
//   rptr_gray        out  ADDR_WIDTH+1  registered Gray read pointer
//   empty            out  1             FIFO empty (pessimistic)
//   almost_empty     out  1             rd_count <= ae_level
//   rd_count         out  ADDR_WIDTH+1  entries available, 0..DEPTH
//   underflow        out  1             sticky: read attempted while empty
// ---------------------------------------------------------------------------
module rd_ptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    input  logic [ADDR_WIDTH:0]   ae_level,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("rd_ptr_ctrl: SYNC_STAGES=%0d outside legal range %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    // -----------------------------------------------------------------------
    // Write-pointer synchroniser
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] wptr_sync;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .d_i    (wptr_gray_async),
        .q_o    (wptr_sync)
    );

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] b_rptr_q,    b_rptr_d;
    logic [PTR_W-1:0] rptr_gray_q, rptr_gray_d;
    logic             empty_q,     empty_d;
    logic             ae_q,        ae_d;
    logic [PTR_W-1:0] count_q,     count_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic             rd_fire;
    logic [PTR_W-1:0] wbin_sync;

    // Use the registered empty flag so that a read can never pass an empty
    // FIFO, even for one cycle.
    assign rd_fire = r_en & ~empty_q;

    assign wbin_sync = PTR_W'(gray2bin(PTR_MAX_W'(wptr_sync), PTR_W));

    always_comb begin
        b_rptr_d    = b_rptr_q + PTR_W'(rd_fire);
        rptr_gray_d = PTR_W'(bin2gray(PTR_MAX_W'(b_rptr_d), PTR_W));
        // Both pointers carry one extra wrap bit, so the modulo-2**PTR_W
        // difference is always 0..DEPTH. The MSB tells full from empty.
        count_d     = wbin_sync - b_rptr_d;
        empty_d     = (rptr_gray_d == wptr_sync);
        ae_d        = (count_d <= ae_level);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr_q    <= '0;
            rptr_gray_q <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            count_q     <= '0;
        end else begin
            b_rptr_q    <= b_rptr_d;
            rptr_gray_q <= rptr_gray_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            count_q     <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Underflow flag
    // -----------------------------------------------------------------------
`ifdef RD_PTR_UNDERFLOW_EN
    logic underflow_q, underflow_d;

    // Set has priority over clear, so a failed read in the same cycle as a
    // clear is not lost.
    always_comb begin
        underflow_d = underflow_q;
        if (err_clr) begin
            underflow_d = 1'b0;
        end
        if (r_en && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign underflow      = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs: straight from registers
    // -----------------------------------------------------------------------
    assign raddr        = b_rptr_q[ADDR_WIDTH-1:0];
    assign rptr_gray    = rptr_gray_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_count     = count_q;

endmodule : rd_ptr_ctrl

// File: tb/tb_rd_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rd_ptr_ctrl
//
// Directed bench for rd_ptr_ctrl with ADDR_WIDTH=3, SYNC_STAGES=2 and
// ae_level=2. Expected underflow behaviour follows RD_PTR_UNDERFLOW_EN.
// ---------------------------------------------------------------------------
module tb_rd_ptr_ctrl;

    localparam int AW = 3;
    localparam int PW = AW + 1;

`ifdef RD_PTR_UNDERFLOW_EN
    localparam logic UF_EN = 1'b1;
`else
    localparam logic UF_EN = 1'b0;
`endif

    logic          rclk;
    logic          rrst_n;
    logic          r_en;
    logic [PW-1:0] wptr_gray_async;
    logic [PW-1:0] ae_level;
    logic          err_clr;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr_gray;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_count;
    logic          underflow;

    int n_chk  = 0;
    int n_fail = 0;

    rd_ptr_ctrl #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (2)
    ) dut (
        .rclk            (rclk),
        .rrst_n          (rrst_n),
        .r_en            (r_en),
        .wptr_gray_async (wptr_gray_async),
        .ae_level        (ae_level),
        .err_clr         (err_clr),
        .raddr           (raddr),
        .rptr_gray       (rptr_gray),
        .empty           (empty),
        .almost_empty    (almost_empty),
        .rd_count        (rd_count),
        .underflow       (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rclk edge; return 1 time unit after it (away from the edge)
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".empty"}, empty, 1);
        check_eq({tag, ".ae"}, almost_empty, 1);
        check_eq({tag, ".count"}, rd_count, 0);
        check_eq({tag, ".rgray"}, rptr_gray, 0);
        check_eq({tag, ".raddr"}, raddr, 0);
        check_eq({tag, ".uflow"}, underflow, 0);
    endtask

    // Gray codes of binary 1..8 for a 4-bit pointer
    logic [PW-1:0] gray_seq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    initial begin
        rrst_n          = 1'b0;
        r_en            = 1'b0;
        wptr_gray_async = '0;
        ae_level        = 4'd2;
        err_clr         = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        check_reset_state("rst");
        rrst_n = 1'b1;
        tick();

        // ---------------- sync latency: wptr 0 -> 1
        wptr_gray_async = 4'b0001;
        tick();
        check_eq("sync.e1.empty", empty, 1);
        tick();
        check_eq("sync.e2.empty", empty, 1);
        check_eq("sync.e2.count", rd_count, 0);
        tick();
        check_eq("sync.e3.empty", empty, 0);
        check_eq("sync.e3.count", rd_count, 1);
        check_eq("sync.e3.ae", almost_empty, 1);

        // ---------------- full drain: wptr bin 8, 8 reads
        wptr_gray_async = 4'b1100;
        tick(); tick(); tick();
        check_eq("drain.pre.count", rd_count, 8);
        check_eq("drain.pre.ae", almost_empty, 0);
        check_eq("drain.pre.empty", empty, 0);
        check_eq("drain.pre.raddr", raddr, 0);
        check_eq("drain.pre.rgray", rptr_gray, 0);
        r_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq($sformatf("drain.%0d.raddr", k), raddr, k % 8);
            check_eq($sformatf("drain.%0d.rgray", k), rptr_gray, gray_seq[k-1]);
            check_eq($sformatf("drain.%0d.count", k), rd_count, 8 - k);
            check_eq($sformatf("drain.%0d.ae", k), almost_empty, (k >= 6) ? 1 : 0);
            check_eq($sformatf("drain.%0d.empty", k), empty, (k == 8) ? 1 : 0);
        end

        // ---------------- underflow: r_en held while empty
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("uf.%0d.raddr", k), raddr, 0);
            check_eq($sformatf("uf.%0d.rgray", k), rptr_gray, 4'hC);
            check_eq($sformatf("uf.%0d.empty", k), empty, 1);
            check_eq($sformatf("uf.%0d.uflow", k), underflow, UF_EN);
        end
        r_en    = 1'b0;
        err_clr = 1'b1;
        tick();
        check_eq("uf.clr.uflow", underflow, 0);
        r_en = 1'b1;
        tick();
        check_eq("uf.setclr.uflow", underflow, UF_EN);
        check_eq("uf.setclr.rgray", rptr_gray, 4'hC);
        r_en = 1'b0;
        tick();
        check_eq("uf.clr2.uflow", underflow, 0);
        err_clr = 1'b0;

        // ---------------- concurrent read + sync update, from count 3
        wptr_gray_async = 4'b1110;   // bin 11
        tick(); tick(); tick();
        check_eq("conc.pre.count", rd_count, 3);
        check_eq("conc.pre.ae", almost_empty, 0);
        wptr_gray_async = 4'b1010;   // bin 12
        tick();
        check_eq("conc.e1.count", rd_count, 3);
        tick();
        check_eq("conc.e2.count", rd_count, 3);
        r_en = 1'b1;                 // read on the edge the new sync value is used
        tick();
        r_en = 1'b0;
        check_eq("conc.e3.count", rd_count, 3);
        check_eq("conc.e3.ae", almost_empty, 0);
        check_eq("conc.e3.raddr", raddr, 1);
        check_eq("conc.e3.rgray", rptr_gray, 4'b1101);

        // ---------------- wrap: bring b_rptr to 15, then wptr bin 1
        wptr_gray_async = 4'b1000;   // bin 15
        tick(); tick(); tick();
        check_eq("wrap.pre.count", rd_count, 6);
        r_en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        r_en = 1'b0;
        check_eq("wrap.b15.rgray", rptr_gray, 4'b1000);
        check_eq("wrap.b15.empty", empty, 1);
        wptr_gray_async = 4'b0001;   // bin 1
        tick(); tick(); tick();
        check_eq("wrap.s.count", rd_count, 2);
        check_eq("wrap.s.empty", empty, 0);
        r_en = 1'b1;
        tick();
        check_eq("wrap.r1.count", rd_count, 1);
        check_eq("wrap.r1.rgray", rptr_gray, 4'b0000);
        tick();
        r_en = 1'b0;
        check_eq("wrap.r2.count", rd_count, 0);
        check_eq("wrap.r2.rgray", rptr_gray, 4'b0001);
        check_eq("wrap.r2.empty", empty, 1);
        check_eq("wrap.r2.ae", almost_empty, 1);

        // ---------------- reset mid-stream with count 5
        wptr_gray_async = 4'b0101;   // bin 6, b_rptr = 1
        tick(); tick(); tick();
        check_eq("mid.pre.count", rd_count, 5);
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset_state("mid");
        tick();
        check_reset_state("mid.held");
        rrst_n = 1'b1;
        tick();
        tick();
        check_eq("mid.rel2.empty", empty, 1);
        check_eq("mid.rel2.count", rd_count, 0);
        tick();
        check_eq("mid.rel3.count", rd_count, 6);
        check_eq("mid.rel3.empty", empty, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_rd_ptr_ctrl
